// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: bus widths, chip
// enable levels, arbiter state encodings and parameter defaults.
package inst_rom_arbiter_pkg;

  localparam int InstAddressBusW = 32;
  localparam int InstDataBusW    = 32;

  localparam logic [InstDataBusW-1:0] ZeroWord = 32'h0000_0000;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  // Arbiter states: fetch-priority and forced debug burst
  typedef enum logic {
    IArbStateIF  = 1'b0,
    IArbStateDBG = 1'b1
  } iarb_state_e;

  localparam int IARB_MAX_WAIT_DEF  = 8;
  localparam int IARB_DBG_BURST_DEF = 4;

  // True when a byte address lies on a 32-bit word boundary
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/inst_rom_arbiter_if.sv
// Bundle of the fetch, debug and ROM-side signals around the arbiter.
// slave  : the arbiter itself
// master : the requesters and the ROM surrounding it
interface inst_rom_arbiter_if;
  import inst_rom_arbiter_pkg::*;

  logic                       if_req;
  logic [InstAddressBusW-1:0] if_addr;
  logic                       if_gnt;
  logic [InstDataBusW-1:0]    if_inst;
  logic                       if_valid;
  logic                       stall_req;

  logic                       dbg_req;
  logic [InstAddressBusW-1:0] dbg_addr;
  logic                       dbg_gnt;
  logic [InstDataBusW-1:0]    dbg_rdata;
  logic                       dbg_valid;

  logic                       rom_ce;
  logic [InstAddressBusW-1:0] rom_addr;
  logic [InstDataBusW-1:0]    rom_inst;

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    output if_gnt, if_inst, if_valid, stall_req,
    output dbg_gnt, dbg_rdata, dbg_valid, rom_ce, rom_addr
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    input  if_gnt, if_inst, if_valid, stall_req,
    input  dbg_gnt, dbg_rdata, dbg_valid, rom_ce, rom_addr
  );

endinterface

// File: rtl/inst_rom_arbiter_resp.sv
// iarb_resp_reg: registered response path for one requester. A grant in
// one cycle becomes a single-cycle valid pulse in the next, carrying the
// ROM word sampled at the closing edge. With CHECK_ALIGN set, a
// misaligned request returns an all-zero word instead of ROM data.
module iarb_resp_reg
  import inst_rom_arbiter_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gnt,
  input  logic [1:0]              addr_lo,
  input  logic [InstDataBusW-1:0] rom_inst,
  output logic                    valid,
  output logic [InstDataBusW-1:0] data
);

  logic                    valid_q, valid_d;
  logic [InstDataBusW-1:0] data_q,  data_d;

  // Next response: pulse on grant, capture (or zero) the word, else hold data
  always_comb begin
    valid_d = gnt;
    data_d  = data_q;
    if (gnt) begin
      if (CHECK_ALIGN && !is_word_aligned(addr_lo)) begin
        data_d = ZeroWord;
      end else begin
        data_d = rom_inst;
      end
    end else begin
      data_d = data_q;
    end
  end

  // Response registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= ZeroWord;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the combinational instruction ROM between the
// fetch stage and a debug/loader port. Fetch has priority; a debug request
// denied MAX_WAIT cycles in a row forces a debug burst of up to DBG_BURST
// grants. Optional macro IARB_PERF_EN adds saturating stall and
// forced-burst counters.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = IARB_MAX_WAIT_DEF,
  parameter int DBG_BURST = IARB_DBG_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  inst_rom_arbiter_if.slave  bus
`ifdef IARB_PERF_EN
  ,
  output logic [31:0]        perf_if_stall,
  output logic [31:0]        perf_dbg_force
`endif
);

  localparam logic [7:0] WaitLast  = 8'(MAX_WAIT - 1);
  localparam logic [7:0] BurstLast = 8'(DBG_BURST - 1);

  iarb_state_e state_q, state_d;
  logic [7:0]  wait_q,  wait_d;
  logic [7:0]  burst_q, burst_d;

  logic if_gnt;
  logic dbg_gnt;
  logic stall_req;

  // Grant decode: fetch priority in S_IF, debug only in S_DBG, none in reset
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if_gnt  = 1'b0;
      dbg_gnt = 1'b0;
    end else begin
      case (state_q)
        IArbStateIF: begin
          if_gnt  = bus.if_req;
          dbg_gnt = bus.dbg_req & ~bus.if_req;
        end
        IArbStateDBG: begin
          if_gnt  = 1'b0;
          dbg_gnt = bus.dbg_req;
        end
        default: begin
          if_gnt  = 1'b0;
          dbg_gnt = 1'b0;
        end
      endcase
    end
  end

  assign stall_req = rst & bus.if_req & ~if_gnt;

  // Next state: starvation counting in S_IF, burst counting in S_DBG
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    case (state_q)
      IArbStateIF: begin
        if (bus.dbg_req && !dbg_gnt) begin
          if (wait_q == WaitLast) begin
            state_d = IArbStateDBG;
            wait_d  = 8'd0;
            burst_d = 8'd0;
          end else begin
            wait_d  = wait_q + 8'd1;
          end
        end else begin
          // Idle debug or a debug grant through idle fetch resets starvation
          wait_d = 8'd0;
        end
      end
      IArbStateDBG: begin
        wait_d = 8'd0;
        if (!bus.dbg_req) begin
          state_d = IArbStateIF;
          burst_d = 8'd0;
        end else if (burst_q == BurstLast) begin
          state_d = IArbStateIF;
          burst_d = 8'd0;
        end else begin
          burst_d = burst_q + 8'd1;
        end
      end
      default: begin
        state_d = IArbStateIF;
        wait_d  = 8'd0;
        burst_d = 8'd0;
      end
    endcase
  end

  // Arbiter state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IArbStateIF;
      wait_q  <= 8'd0;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  // ROM port mux: address of the current owner, zero when idle
  always_comb begin
    bus.rom_addr = ZeroWord;
    if (if_gnt) begin
      bus.rom_addr = bus.if_addr;
    end else if (dbg_gnt) begin
      bus.rom_addr = bus.dbg_addr;
    end else begin
      bus.rom_addr = ZeroWord;
    end
  end

  assign bus.rom_ce    = (if_gnt | dbg_gnt) ? ChipEnable : ChipDisable;
  assign bus.if_gnt    = if_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.stall_req = stall_req;

  // Fetch response: misaligned fetch addresses pass through untouched
  iarb_resp_reg #(.CHECK_ALIGN(1'b0)) u_if_resp (
    .clk      (clk),
    .rst      (rst),
    .gnt      (if_gnt),
    .addr_lo  (bus.if_addr[1:0]),
    .rom_inst (bus.rom_inst),
    .valid    (bus.if_valid),
    .data     (bus.if_inst)
  );

  // Debug response: misaligned reads return zero
  iarb_resp_reg #(.CHECK_ALIGN(1'b1)) u_dbg_resp (
    .clk      (clk),
    .rst      (rst),
    .gnt      (dbg_gnt),
    .addr_lo  (bus.dbg_addr[1:0]),
    .rom_inst (bus.rom_inst),
    .valid    (bus.dbg_valid),
    .data     (bus.dbg_rdata)
  );

`ifdef IARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_force_q, perf_force_d;
  logic        force_evt;

  assign force_evt = (state_q == IArbStateIF) && (state_d == IArbStateDBG);

  // Saturating performance counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_force_d = perf_force_q;
    if (stall_req && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (force_evt && (perf_force_q != 32'hFFFF_FFFF)) begin
      perf_force_d = perf_force_q + 32'd1;
    end else begin
      perf_force_d = perf_force_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_force_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_force_q <= perf_force_d;
    end
  end

  assign perf_if_stall  = perf_stall_q;
  assign perf_dbg_force = perf_force_q;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter (MAX_WAIT=8, DBG_BURST=4).
// A transaction-level model tracks starvation runs and remaining burst
// grants; one compare process checks all outputs each cycle, and directed
// sections pin the model with hand-computed literals.
module tb_inst_rom_arbiter;

  localparam int MAXW  = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  inst_rom_arbiter_if bus();

`ifdef IARB_PERF_EN
  logic [31:0] perf_if_stall, perf_dbg_force;
`endif

  inst_rom_arbiter #(.MAX_WAIT(MAXW), .DBG_BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IARB_PERF_EN
    ,
    .perf_if_stall  (perf_if_stall),
    .perf_dbg_force (perf_dbg_force)
`endif
  );

  always #5 clk = ~clk;

  // ROM content: word k holds 0xA000_0000 + k
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_burst_left;   // forced debug grants still available
  int          m_denied;       // consecutive cycles debug was refused
  logic        m_if_valid, m_dbg_valid;
  logic [31:0] m_if_inst, m_dbg_rdata;
  int          m_stall_cnt, m_force_cnt;
  logic        e_if_gnt, e_dbg_gnt, e_stall;
  logic [31:0] e_rom_addr;

  always_comb begin
    e_if_gnt  = 1'b0;
    e_dbg_gnt = 1'b0;
    if (rst) begin
      if (m_burst_left > 0) begin
        e_dbg_gnt = bus.dbg_req;
      end else begin
        e_if_gnt  = bus.if_req;
        e_dbg_gnt = bus.dbg_req && !bus.if_req;
      end
    end
    e_stall    = rst && bus.if_req && !e_if_gnt;
    e_rom_addr = e_if_gnt ? bus.if_addr : (e_dbg_gnt ? bus.dbg_addr : 32'h0);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_burst_left <= 0;
      m_denied     <= 0;
      m_if_valid   <= 1'b0;
      m_dbg_valid  <= 1'b0;
      m_if_inst    <= 32'h0;
      m_dbg_rdata  <= 32'h0;
      m_stall_cnt  <= 0;
      m_force_cnt  <= 0;
    end else begin
      if (m_burst_left > 0) begin
        m_denied     <= 0;
        m_burst_left <= bus.dbg_req ? m_burst_left - 1 : 0;
      end else if (bus.dbg_req && !e_dbg_gnt) begin
        if (m_denied + 1 == MAXW) begin
          m_burst_left <= BURST;
          m_denied     <= 0;
          m_force_cnt  <= m_force_cnt + 1;
        end else begin
          m_denied <= m_denied + 1;
        end
      end else begin
        m_denied <= 0;
      end
      if (e_stall) m_stall_cnt <= m_stall_cnt + 1;
      m_if_valid  <= e_if_gnt;
      m_dbg_valid <= e_dbg_gnt;
      if (e_if_gnt) m_if_inst <= rom_word(bus.if_addr);
      if (e_dbg_gnt) m_dbg_rdata <= (bus.dbg_addr[1:0] != 2'b00) ? 32'h0 : rom_word(bus.dbg_addr);
    end
  end

  // Compare process: every output against the model, every cycle
  always @(negedge clk) begin
    chk("if_gnt",    {31'd0, bus.if_gnt},    {31'd0, e_if_gnt});
    chk("dbg_gnt",   {31'd0, bus.dbg_gnt},   {31'd0, e_dbg_gnt});
    chk("stall_req", {31'd0, bus.stall_req}, {31'd0, e_stall});
    chk("rom_ce",    {31'd0, bus.rom_ce},    {31'd0, e_if_gnt | e_dbg_gnt});
    chk("rom_addr",  bus.rom_addr, e_rom_addr);
    chk("exclusive", {31'd0, bus.if_gnt & bus.dbg_gnt}, 32'd0);
    chk("if_valid",  {31'd0, bus.if_valid},  {31'd0, m_if_valid});
    chk("dbg_valid", {31'd0, bus.dbg_valid}, {31'd0, m_dbg_valid});
    if (m_if_valid)  chk("if_inst",   bus.if_inst,   m_if_inst);
    if (m_dbg_valid) chk("dbg_rdata", bus.dbg_rdata, m_dbg_rdata);
`ifdef IARB_PERF_EN
    chk("perf_if_stall",  perf_if_stall,  32'(m_stall_cnt));
    chk("perf_dbg_force", perf_dbg_force, 32'(m_force_cnt));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [12:0] ig_v, dg_v, st_v;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h20;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = 32'h0;

    // 1. reset held three cycles with fetch requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_if_gnt",   {31'd0, bus.if_gnt},    32'd0);
      chk("rst_stall",    {31'd0, bus.stall_req}, 32'd0);
      chk("rst_if_valid", {31'd0, bus.if_valid},  32'd0);
      chk("rst_rom_ce",   {31'd0, bus.rom_ce},    32'd0);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("rel_if_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("rel_if_inst",  bus.if_inst, 32'hA000_0008);

    // 2. fetch stream 0x0, 0x4, 0x8
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    step();
    bus.if_addr = 32'h4;
    @(negedge clk);
    chk("f0_inst", bus.if_inst, 32'hA000_0000);
    step();
    bus.if_addr = 32'h8;
    @(negedge clk);
    chk("f1_inst", bus.if_inst, 32'hA000_0001);
    chk("f1_stall", {31'd0, bus.stall_req}, 32'd0);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f2_inst",  bus.if_inst, 32'hA000_0002);
    chk("f2_valid", {31'd0, bus.if_valid}, 32'd1);

    // 3. debug read while fetch is idle
    step();
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h10;
    @(negedge clk);
    chk("d_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    step();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("d_valid", {31'd0, bus.dbg_valid}, 32'd1);
    chk("d_rdata", bus.dbg_rdata, 32'hA000_0004);

    // 4. starvation: 8 fetch grants, 4 debug grants, then fetch again
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h80;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ig_v[i] = bus.if_gnt;
      dg_v[i] = bus.dbg_gnt;
      st_v[i] = bus.stall_req;
    end
    chk("starve_if",    {19'd0, ig_v}, 32'h0000_10FF);
    chk("starve_dbg",   {19'd0, dg_v}, 32'h0000_0F00);
    chk("starve_stall", {19'd0, st_v}, 32'h0000_0F00);
    step();
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    step();

    // 5. misaligned debug address returns zero
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h6;
    @(negedge clk);
    chk("mis_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    step();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("mis_valid", {31'd0, bus.dbg_valid}, 32'd1);
    chk("mis_rdata", bus.dbg_rdata, 32'h0000_0000);

    // 6. reset during the second cycle of a forced burst
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h14;
    repeat (9) @(posedge clk);
    #1;
    chk("mb_dbg_gnt_pre", {31'd0, bus.dbg_gnt}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mb_rst_dbg_gnt", {31'd0, bus.dbg_gnt},   32'd0);
    chk("mb_rst_valid",   {31'd0, bus.dbg_valid}, 32'd0);
`ifdef IARB_PERF_EN
    chk("mb_perf_stall", perf_if_stall,  32'd0);
    chk("mb_perf_force", perf_dbg_force, 32'd0);
`endif
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mb_if_gnt",    {31'd0, bus.if_gnt},    32'd1);
    chk("mb_dbg_gnt",   {31'd0, bus.dbg_gnt},   32'd0);
    chk("mb_dbg_valid", {31'd0, bus.dbg_valid}, 32'd0);
    step();
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("mb_if_inst", bus.if_inst, 32'hA000_0003);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
